// File: rtl/lighthouse_pulse_decoder.sv
// Photodiode pulse decoder: synchronise, deglitch, measure high width, classify as
// LASER / sync code / INTERVAL, and time laser hits against the last non-skip sync.
module lighthouse_pulse_decoder #(
    parameter int W         = 16,
    parameter int TS_W      = 20,
    parameter int DEGLITCH  = 2,
    parameter int LASER_MAX = 1200,
    parameter int SYNC_BASE = 3000,
    parameter int SYNC_STEP = 500,
    parameter int SYNC_TOL  = 200,
    parameter int SWEEP_MAX = 400000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pulse_in,
    output logic            evt_valid,
    output logic [3:0]      evt_type,
    output logic [W-1:0]    evt_width,
    output logic            sweep_valid,
    output logic            sweep_axis,
    output logic [TS_W-1:0] sweep_ticks
);

    localparam int DG_W = (DEGLITCH < 2) ? 1 : $clog2(DEGLITCH + 1);
    localparam logic [W-1:0]    WMAX   = '1;
    localparam logic [TS_W-1:0] SW_MAX = TS_W'(SWEEP_MAX);

    typedef enum logic {S_IDLE, S_ARMED} state_t;

    logic            r_sync1, r_sync2;
    logic            r_p, r_p_d;
    logic [DG_W-1:0] r_dg_cnt;
    logic [TS_W-1:0] r_ts, r_rise_ts, r_sync_ts;
    logic [W-1:0]    r_width;
    logic            r_sync_axis;
    state_t          r_state, w_state_next;

    logic            w_diff, w_flip, w_p_next, w_fall;
    int              w_wi;
    logic            w_laser, w_sync;
    logic [2:0]      w_k;
    logic [3:0]      w_type;
    logic            w_is_laser, w_is_arm, w_sweep_fire;
    logic [TS_W-1:0] w_t, w_age;

    // The filtered level only follows the synced input after DEGLITCH consecutive
    // differing cycles, so both edges are delayed equally and widths are preserved.
    assign w_diff   = r_sync2 != r_p;
    assign w_flip   = w_diff && (r_dg_cnt == DG_W'(DEGLITCH - 1));
    assign w_p_next = w_flip ? r_sync2 : r_p;
    assign w_fall   = r_p_d && !r_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_p      <= 1'b0;
            r_p_d    <= 1'b0;
            r_dg_cnt <= '0;
            r_ts     <= '0;
        end else begin
            r_sync1  <= pulse_in;
            r_sync2  <= r_sync1;
            r_p      <= w_p_next;
            r_p_d    <= r_p;
            r_dg_cnt <= (!w_diff || w_flip) ? '0 : r_dg_cnt + DG_W'(1);
            r_ts     <= r_ts + TS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_width   <= '0;
            r_rise_ts <= '0;
        end else if (w_p_next && !r_p) begin
            r_width   <= W'(1);
            r_rise_ts <= r_ts;
        end else if (w_p_next && r_p && r_width != WMAX) begin
            r_width   <= r_width + W'(1);
        end
    end

    // Classification: LASER wins, then the lowest matching sync code, else INTERVAL.
    always_comb begin
        w_wi    = int'(r_width);
        w_laser = 1'b0;
        w_sync  = 1'b0;
        w_k     = 3'd0;
        if (r_width != WMAX) begin
            if (w_wi >= 1 && w_wi < LASER_MAX) begin
                w_laser = 1'b1;
            end else begin
                for (int k = 7; k >= 0; k--) begin
                    if (w_wi > SYNC_BASE + k * SYNC_STEP - SYNC_TOL &&
                        w_wi < SYNC_BASE + k * SYNC_STEP + SYNC_TOL) begin
                        w_sync = 1'b1;
                        w_k    = 3'(k);
                    end
                end
            end
        end
        if (w_laser)     w_type = 4'd0;
        else if (w_sync) w_type = {1'b0, w_k} + 4'd1;
        else             w_type = 4'd9;
    end

    assign w_is_laser = w_fall && w_laser;
    assign w_is_arm   = w_fall && w_sync && !w_k[2];
    assign w_t        = r_rise_ts + TS_W'(r_width >> 1) - r_sync_ts;
    assign w_age      = r_ts - r_sync_ts;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // A laser landing in the same cycle as the timeout is judged by its own t.
    always_comb begin
        w_state_next = r_state;
        w_sweep_fire = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_is_arm) w_state_next = S_ARMED;
            end
            S_ARMED: begin
                if (w_is_laser) begin
                    w_state_next = S_IDLE;
                    w_sweep_fire = (w_t <= SW_MAX);
                end else if (w_is_arm) begin
                    w_state_next = S_ARMED;
                end else if (w_age > SW_MAX) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_ts   <= '0;
            r_sync_axis <= 1'b0;
        end else if (w_is_arm) begin
            r_sync_ts   <= r_rise_ts;
            r_sync_axis <= w_k[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid   <= 1'b0;
            evt_type    <= '0;
            evt_width   <= '0;
            sweep_valid <= 1'b0;
            sweep_axis  <= 1'b0;
            sweep_ticks <= '0;
        end else begin
            evt_valid   <= w_fall;
            sweep_valid <= w_sweep_fire;
            if (w_fall) begin
                evt_type  <= w_type;
                evt_width <= r_width;
            end
            if (w_sweep_fire) begin
                sweep_axis  <= r_sync_axis;
                sweep_ticks <= w_t;
            end
        end
    end

endmodule

// File: tb/tb_lighthouse_pulse_decoder.sv
// Directed bench for lighthouse_pulse_decoder; timestamp, width and sweep window are
// narrowed so wrap, saturation and timeout are reachable in a short run.
module tb_lighthouse_pulse_decoder;

    localparam int DG   = 2;
    localparam int W    = 13;
    localparam int TS_W = 13;
    localparam int SMAX = 4000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            pulse_in = 1'b0;
    logic            evt_valid;
    logic [3:0]      evt_type;
    logic [W-1:0]    evt_width;
    logic            sweep_valid;
    logic            sweep_axis;
    logic [TS_W-1:0] sweep_ticks;

    lighthouse_pulse_decoder #(
        .W(W), .TS_W(TS_W), .DEGLITCH(DG), .LASER_MAX(1200), .SYNC_BASE(3000),
        .SYNC_STEP(500), .SYNC_TOL(200), .SWEEP_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst), .pulse_in(pulse_in),
        .evt_valid(evt_valid), .evt_type(evt_type), .evt_width(evt_width),
        .sweep_valid(sweep_valid), .sweep_axis(sweep_axis), .sweep_ticks(sweep_ticks)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int n_evt = 0, n_sw = 0, l_type = 0, l_width = 0, l_ticks = 0, l_axis = 0, bad_align = 0;
    int cyc = 0;
    int e0, s0;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (evt_valid) begin
            n_evt   = n_evt + 1;
            l_type  = int'(evt_type);
            l_width = int'(evt_width);
        end
        if (sweep_valid) begin
            n_sw    = n_sw + 1;
            l_ticks = int'(sweep_ticks);
            l_axis  = int'(sweep_axis);
            if (!evt_valid) bad_align = bad_align + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int hi);
        pulse_in = 1'b1;
        step(hi);
        pulse_in = 1'b0;
    endtask

    task automatic cls(input string tag, input int hi, input int exp_type, input int exp_w);
        int b;
        b = n_evt;
        pulse(hi);
        step(DG + 4);
        chk({tag, "_n"}, n_evt - b, 1);
        chk({tag, "_type"}, l_type, exp_type);
        chk({tag, "_width"}, l_width, exp_w);
        step(20);
    endtask

    initial begin
        step(3);
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_evt_type", evt_type, 0);
        chk("rst_evt_width", evt_width, 0);
        chk("rst_sweep_valid", sweep_valid, 0);
        chk("rst_sweep_axis", sweep_axis, 0);
        chk("rst_sweep_ticks", sweep_ticks, 0);
        rst = 1'b0;
        step(5);

        // Event appears exactly DG+3 edges after the input fall, for one cycle.
        pulse(3000);
        step(DG + 2);
        chk("lat_early", evt_valid, 0);
        step(1);
        chk("lat_valid", evt_valid, 1);
        chk("lat_type", evt_type, 1);
        chk("lat_width", evt_width, 3000);
        step(1);
        chk("lat_strobe", evt_valid, 0);
        step(20);

        cls("w2800", 2800, 9, 2800);
        cls("w2801", 2801, 1, 2801);
        cls("w3199", 3199, 1, 3199);
        cls("w3200", 3200, 9, 3200);
        cls("w4500", 4500, 4, 4500);
        cls("w6500", 6500, 8, 6500);
        cls("w1199", 1199, 0, 1199);
        cls("w1200", 1200, 9, 1200);
        cls("w2", 2, 0, 2);

        e0 = n_evt;
        pulse(1);
        step(20);
        chk("glitch_n", n_evt - e0, 0);

        cls("sat", 9000, 9, 8191);

        // Sync rise at S, laser rise at S+3500 width 400 -> 3500+200.
        e0 = n_evt; s0 = n_sw;
        pulse(3000);
        step(500);
        pulse(400);
        step(DG + 4);
        chk("sw_n", n_sw - s0, 1);
        chk("sw_ticks", l_ticks, 3700);
        chk("sw_axis", l_axis, 0);
        chk("sw_type", l_type, 0);
        step(100);
        pulse(400);
        step(DG + 4);
        chk("sw2_nosweep", n_sw - s0, 1);
        chk("sw2_evt", n_evt - e0, 3);
        chk("sw2_type", l_type, 0);
        step(20);

        // Sync k=1 (axis 1), laser at +3600 width 100 -> 3650.
        s0 = n_sw;
        pulse(3500);
        step(100);
        pulse(100);
        step(DG + 4);
        chk("ax1_n", n_sw - s0, 1);
        chk("ax1_ticks", l_ticks, 3650);
        chk("ax1_axis", l_axis, 1);
        step(20);

        // Laser 4001 ticks after sync rise: beyond the sweep window.
        e0 = n_evt; s0 = n_sw;
        pulse(3500);
        step(501);
        pulse(400);
        step(DG + 4);
        chk("tmo_nosweep", n_sw - s0, 0);
        chk("tmo_evt", n_evt - e0, 2);
        chk("tmo_type", l_type, 0);
        step(20);

        // Arm, then reset in the middle of a pulse that stays high afterwards.
        pulse(3000);
        step(20);
        pulse_in = 1'b1;
        step(500);
        rst = 1'b1;
        step(3);
        chk("mid_rst_evt", evt_valid, 0);
        chk("mid_rst_width", evt_width, 0);
        e0 = n_evt; s0 = n_sw;
        rst = 1'b0;
        step(700);
        pulse_in = 1'b0;
        step(DG + 4);
        chk("mid_n", n_evt - e0, 1);
        chk("mid_width", l_width, 700);
        chk("mid_type", l_type, 0);
        chk("mid_nosweep", n_sw - s0, 0);
        step(20);

        // Sync rises just before the timestamp wraps, laser lands after it.
        step(8170 - (cyc % 8192));
        s0 = n_sw;
        pulse(3000);
        step(500);
        pulse(400);
        step(DG + 4);
        chk("wrap_n", n_sw - s0, 1);
        chk("wrap_ticks", l_ticks, 3700);
        chk("wrap_axis", l_axis, 0);

        chk("sweep_align", bad_align, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
